dmem_responder: RTL

- Data-memory responder for the CPU's data port; it is the memory end of the dm_addr/dm_wdata/dm_web/dm_rdata interface.
- Provides a byte-maskable synchronous RAM with a one-cycle registered read.
- Adds a small MMIO window: a 64-bit cycle counter, a TOHOST completion register and a status word.
- Used as the testbench and simulation data memory, and as the FPGA data memory.

---
 rtl/dmem_pkg.sv | 30 +++
 rtl/dmem_responder_counter.sv | 28 ++
 rtl/dmem_responder.sv | 118 +++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory responder: MMIO register
// offsets, the read-cycle write-enable pattern and the address-region decode.
package dmem_pkg;

   localparam logic [3:0] OFF_CYCLE_LO = 4'h0;
   localparam logic [3:0] OFF_CYCLE_HI = 4'h4;
   localparam logic [3:0] OFF_TOHOST   = 4'h8;
   localparam logic [3:0] OFF_STATUS   = 4'hC;

   localparam logic [3:0] WEB_READ = 4'b1111;

   typedef enum logic [1:0] {
      REG_RAM,
      REG_MMIO,
      REG_NONE
   } region_e;

   // Byte-lane merge: lanes whose active-low enable is 0 take new_w, others keep old_w.
   function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  web);
      logic [31:0] res;
      res = old_w;
      for (int i = 0; i < 4; i++) begin
         if (!web[i]) res[8*i +: 8] = new_w[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/dmem_responder_counter.sv
// Free-running 64-bit cycle counter with a high-word shadow captured whenever
// the low word is read, so a LO-then-HI read pair is coherent.
module cycle_counter64 (
   input  logic        clk,
   input  logic        rst,
   input  logic        snap_lo_i,
   output logic [31:0] lo_o,
   output logic [31:0] hi_o
);

   logic [63:0] count_q;
   logic [31:0] hi_shadow_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q     <= '0;
         hi_shadow_q <= '0;
      end else begin
         count_q <= count_q + 64'd1;
         if (snap_lo_i) hi_shadow_q <= count_q[63:32];
      end
   end

   assign lo_o = count_q[31:0];
   assign hi_o = hi_shadow_q;

endmodule

// File: rtl/dmem_responder.sv
// Memory end of the CPU data port: byte-maskable synchronous RAM with a
// registered read, plus a 16-byte MMIO window (cycle counter, TOHOST, status).
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 16384,
   parameter logic [31:0] RAM_BASE    = 32'h0000_0000,
   parameter logic [31:0] MMIO_BASE   = 32'h1000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   input  logic [3:0]  dm_web,
   output logic [31:0] dm_rdata,
   output logic        done,
   output logic [31:0] done_code,
   output logic        access_err
);

   localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
   localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

   logic [31:0]      ram_off;
   logic [IDX_W-1:0] word_idx;
   logic [3:0]       mmio_off;
   region_e          region;
   logic [3:0]       ram_we;
   logic             tohost_wr;
   logic             snap_lo;
   logic [31:0]      cyc_lo, cyc_hi;

   logic [31:0] ram_q [DEPTH_WORDS];

   logic [31:0] rdata_q, rdata_d;
   logic        done_q, done_d;
   logic [31:0] code_q, code_d;
   logic        err_q, err_d;

   assign ram_off  = dm_addr - RAM_BASE;
   assign word_idx = ram_off[IDX_W+1:2];
   assign mmio_off = {dm_addr[3:2], 2'b00};

   always_comb begin
      if (ram_off < RAM_BYTES)                region = REG_RAM;
      else if (dm_addr[31:4] == MMIO_BASE[31:4]) region = REG_MMIO;
      else                                    region = REG_NONE;
   end

   // Stores are suppressed while reset is held so a store racing reset is dropped.
   always_comb begin
      ram_we = '0;
      if (region == REG_RAM && !rst) ram_we = ~dm_web;
   end

   // NOTE: the RAM array has no reset; clearing it would block RAM inference and is not required.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (ram_we[i]) ram_q[word_idx][8*i +: 8] <= dm_wdata[8*i +: 8];
      end
   end

   assign snap_lo   = (region == REG_MMIO) && (mmio_off == OFF_CYCLE_LO) && (dm_web == WEB_READ);
   assign tohost_wr = (region == REG_MMIO) && (mmio_off == OFF_TOHOST) && (dm_web != WEB_READ)
                      && !done_q;

   cycle_counter64 u_cnt (
      .clk       (clk),
      .rst       (rst),
      .snap_lo_i (snap_lo),
      .lo_o      (cyc_lo),
      .hi_o      (cyc_hi)
   );

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      rdata_d = '0;
      done_d  = done_q;
      code_d  = code_q;
      err_d   = err_q;
      unique case (region)
         REG_RAM:  rdata_d = ram_q[word_idx];
         REG_MMIO: begin
            unique case (mmio_off)
               OFF_CYCLE_LO: rdata_d = cyc_lo;
               OFF_CYCLE_HI: rdata_d = cyc_hi;
               OFF_TOHOST:   rdata_d = code_q;
               default:      rdata_d = {31'b0, done_q};
            endcase
         end
         default:  err_d = 1'b1;
      endcase
      if (tohost_wr) begin
         done_d = 1'b1;
         code_d = merge_lanes(32'h0, dm_wdata, dm_web);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q <= '0;
         done_q  <= 1'b0;
         code_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         rdata_q <= rdata_d;
         done_q  <= done_d;
         code_q  <= code_d;
         err_q   <= err_d;
      end
   end

   assign dm_rdata   = rdata_q;
   assign done       = done_q;
   assign done_code  = code_q;
   assign access_err = err_q;

endmodule
